idct_apx_sched: RTL
===================

# idct_apx_sched

Run-level scheduler for the dct → idct approximate-precision pipeline. It accepts a frame of N 8×8 blocks, then:
- drives `dct_start` while input samples are needed;
- counts the 64-cycle coefficient and pixel bursts;
- selects the idct precision (`idct_rapx`) per block from a programmable block-index window;
- drains the pipeline with a bounded timeout.

It sits between the frame source and the `dct`/`idct` pair and replaces the sequencing currently done by the bench.

## Interface
- `BLK_W`, 16: width of block counters and window bounds.
- `DRAIN_CYC`, 16384: maximum cycles spent in DRAIN before a forced finish.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `go` in 1: one-cycle start request; honoured only in IDLE.
- `abort` in 1: synchronous abort; has priority over every other input.
- `cfg_nblk` in BLK_W: number of blocks in the run; sampled on `go`.
- `cfg_apx_en` in 1: enables approximate mode; sampled on `go`.
- `cfg_apx_lo` in BLK_W: inclusive lower bound of the approximate-mode block window; sampled on `go`.
- `cfg_apx_hi` in BLK_W: exclusive upper bound of the approximate-mode block window; sampled on `go`.
- `dct_reading` in 1: dct accepts one sample this cycle.
- `dct_done` in 1: dct coefficient burst is active.
- `idct_done` in 1: idct pixel burst is active.
- `dct_start` out 1: start/hold signal to the dct.
- `idct_racc` out 1: accurate-path reset to the idct.
- `idct_rapx` out 1: approximate-mode select to the idct.
- `pix_valid` out 1: qualifies `idct` dout for capture.
- `coef_valid` out 1: qualifies `dct` dout for capture.
- `busy` out 1: high in RUN or DRAIN.
- `fin` out 1: one-cycle pulse marking the end of a run.
- `timeout` out 1: sticky; set when DRAIN expires.
- `blk_out` out BLK_W: number of completed idct blocks.

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - `idct_racc`=1; all other outputs hold reset values.
  - On `go` with `cfg_nblk`≠0: latch the config, clear counters and `timeout`, go to RUN.
  - `go` with `cfg_nblk`=0: ignored.
- RUN:
  - `dct_start`=1, `idct_racc`=0.
  - `in_cnt` (6 bit) increments on each `dct_reading`.
  - On wrap 63→0, `blk_in` increments.
  - When the 64th sample of block `cfg_nblk`−1 is accepted, go to DRAIN. `dct_start` is 0 from the next cycle.
- Coefficient tracking (RUN and DRAIN):
  - `coef_cnt` counts cycles with `dct_done`=1, saturating at 64.
  - `coef_valid` = `dct_done` & (`coef_cnt`<64).
  - `coef_cnt` clears on any cycle with `dct_done`=0.
  - On the first cycle of each `dct_done` burst (0→1 edge), `blk_coef` increments.
  - At that same edge, `idct_rapx` is registered to `cfg_apx_en` & (`cfg_apx_lo` ≤ k < `cfg_apx_hi`), where k is the pre-increment `blk_coef`.
  - `idct_rapx` holds until the next burst edge.
  - An empty window (lo ≥ hi) gives a constant 0.
- Pixel tracking:
  - `pix_cnt` behaves like `coef_cnt` but on `idct_done`.
  - `pix_valid` = `idct_done` & (`pix_cnt`<64).
  - On the 64th valid pixel, `blk_out` increments.
- DRAIN:
  - `drain_cnt` counts up from 0.
  - When `blk_out` = `cfg_nblk`, go to FIN.
  - When `drain_cnt` reaches `DRAIN_CYC`−1 with blocks still outstanding, set `timeout` and go to FIN.
  - If both conditions occur in the same cycle, completion wins and `timeout` stays 0.
- FIN: `fin`=1 for one cycle, then IDLE.
  - `blk_out` and `timeout` hold until the next accepted `go`.
- `abort` in any state:
  - Next state is IDLE.
  - All counters clear, except `blk_out` and `timeout`, which hold.
  - No `fin` pulse is generated.
- Counters are unsigned.
  - `blk_in`, `blk_coef` and `blk_out` never exceed `cfg_nblk`.
  - Extra bursts after `cfg_nblk` still produce `coef_valid`/`pix_valid`, but do not increment the block counters.

## Timing
- Reset values:
  - `idct_racc`=1.
  - `dct_start`, `idct_rapx`, `pix_valid`, `coef_valid`, `busy`, `fin`, `timeout` = 0.
  - `blk_out` = 0.
  - State = IDLE.
- Reset is asynchronous mid-run: outputs reach reset values immediately, with no drain.
- `go` at edge t: `busy`=1 and `dct_start`=1 at t+1; `idct_racc`=0 at t+1.
- `coef_valid` and `pix_valid` are combinational from `dct_done`/`idct_done` and the registered counts, so they have zero latency.
- `idct_rapx` becomes valid one cycle after the `dct_done` rising edge. This edge is where the idct samples its start.
- `fin` is asserted one cycle after the completion or timeout condition.
- `busy` drops in the same cycle `fin` rises.

## Test plan
- Single block, `cfg_nblk`=1, `go`, 64 `dct_reading` cycles, dct/idct stubs emit 64-cycle bursts → 64 `coef_valid`, 64 `pix_valid`, `blk_out`=1, one `fin`, `timeout`=0.
- QCIF run, `cfg_nblk`=396, window lo=100 hi=200, `cfg_apx_en`=1 → `idct_rapx`=1 exactly during bursts 100–199; `blk_out`=396.
- Burst longer than 64: `idct_done` held 70 cycles → `pix_valid` high for 64 cycles only; `blk_out` increments once.
- Stalled idct, `DRAIN_CYC`=32, `cfg_nblk`=2, only one pixel burst → `fin` 32 cycles after DRAIN entry, `timeout`=1, `blk_out`=1.
- `abort` asserted mid-RUN at sample 30 of block 3 → IDLE next cycle, `dct_start`=0, no `fin`, `idct_racc`=1.
- Async reset mid-DRAIN → all outputs at reset values before the next edge; a following `go` with `cfg_nblk`=0 is ignored and `busy` stays 0.

Source files
------------

// File: rtl/idct_apx_sched.sv
// Run-level scheduler for the dct -> idct approximate-precision pipeline: sequences sample
// intake, tracks coefficient/pixel bursts, selects idct precision per block and bounds the drain.
module idct_apx_sched #(
  parameter int BLK_W     = 16,
  parameter int DRAIN_CYC = 16384
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  input  logic [BLK_W-1:0] cfg_nblk,
  input  logic             cfg_apx_en,
  input  logic [BLK_W-1:0] cfg_apx_lo,
  input  logic [BLK_W-1:0] cfg_apx_hi,
  input  logic             dct_reading,
  input  logic             dct_done,
  input  logic             idct_done,
  output logic             dct_start,
  output logic             idct_racc,
  output logic             idct_rapx,
  output logic             pix_valid,
  output logic             coef_valid,
  output logic             busy,
  output logic             fin,
  output logic             timeout,
  output logic [BLK_W-1:0] blk_out
);
  localparam int            DW         = $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [BLK_W-1:0] nblk_q, nblk_d;
  logic [BLK_W-1:0] apx_lo_q, apx_lo_d;
  logic [BLK_W-1:0] apx_hi_q, apx_hi_d;
  logic             apx_en_q, apx_en_d;
  logic [5:0]       in_cnt_q, in_cnt_d;
  logic [BLK_W-1:0] blk_in_q, blk_in_d;
  logic [BLK_W-1:0] blk_coef_q, blk_coef_d;
  logic [BLK_W-1:0] blk_out_q, blk_out_d;
  logic [6:0]       coef_cnt_q, coef_cnt_d;
  logic [6:0]       pix_cnt_q, pix_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             rapx_q, rapx_d;
  logic             timeout_q, timeout_d;
  logic             dct_start_q, racc_q, busy_q, fin_q;

  logic             track, coef_edge, pix_last;

  // Burst length counter: clears outside a burst, saturates at 64.
  function automatic logic [6:0] sat_burst(input logic hit, input logic [6:0] cnt);
    if (!hit)              sat_burst = 7'd0;
    else if (cnt == 7'd64) sat_burst = cnt;
    else                   sat_burst = cnt + 7'd1;
  endfunction

  function automatic logic in_window(input logic en, input logic [BLK_W-1:0] lo,
                                     input logic [BLK_W-1:0] hi, input logic [BLK_W-1:0] k);
    in_window = en && (k >= lo) && (k < hi);
  endfunction

  assign track      = (state_q == RUN) || (state_q == DRAIN);
  assign coef_valid = track && dct_done && (coef_cnt_q < 7'd64);
  assign pix_valid  = track && idct_done && (pix_cnt_q < 7'd64);
  assign coef_edge  = track && dct_done && (coef_cnt_q == 7'd0);
  assign pix_last   = pix_valid && (pix_cnt_q == 7'd63);

  always_comb begin
    state_d     = state_q;
    nblk_d      = nblk_q;
    apx_lo_d    = apx_lo_q;
    apx_hi_d    = apx_hi_q;
    apx_en_d    = apx_en_q;
    in_cnt_d    = in_cnt_q;
    blk_in_d    = blk_in_q;
    blk_coef_d  = blk_coef_q;
    blk_out_d   = blk_out_q;
    drain_cnt_d = drain_cnt_q;
    rapx_d      = rapx_q;
    timeout_d   = timeout_q;
    coef_cnt_d  = sat_burst(track && dct_done, coef_cnt_q);
    pix_cnt_d   = sat_burst(track && idct_done, pix_cnt_q);

    // Precision is chosen from the pre-increment block index at the burst's first cycle.
    if (coef_edge) begin
      rapx_d = in_window(apx_en_q, apx_lo_q, apx_hi_q, blk_coef_q);
      if (blk_coef_q < nblk_q) blk_coef_d = blk_coef_q + 1'b1;
    end
    if (pix_last && (blk_out_q < nblk_q)) blk_out_d = blk_out_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (go && (cfg_nblk != '0)) begin
          state_d     = RUN;
          nblk_d      = cfg_nblk;
          apx_en_d    = cfg_apx_en;
          apx_lo_d    = cfg_apx_lo;
          apx_hi_d    = cfg_apx_hi;
          in_cnt_d    = '0;
          blk_in_d    = '0;
          blk_coef_d  = '0;
          blk_out_d   = '0;
          drain_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end
      RUN: begin
        if (dct_reading) begin
          in_cnt_d = in_cnt_q + 6'd1;
          if (in_cnt_q == 6'd63) begin
            if (blk_in_q < nblk_q) blk_in_d = blk_in_q + 1'b1;
            if (blk_in_q == nblk_q - 1'b1) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (blk_out_q == nblk_q) begin
          state_d = FIN;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; completed-block count and timeout survive it.
    if (abort) begin
      state_d     = IDLE;
      in_cnt_d    = '0;
      blk_in_d    = '0;
      blk_coef_d  = '0;
      coef_cnt_d  = '0;
      pix_cnt_d   = '0;
      drain_cnt_d = '0;
      blk_out_d   = blk_out_q;
      timeout_d   = timeout_q;
    end
    if ((state_d != RUN) && (state_d != DRAIN)) rapx_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      nblk_q      <= '0;
      apx_lo_q    <= '0;
      apx_hi_q    <= '0;
      apx_en_q    <= 1'b0;
      in_cnt_q    <= '0;
      blk_in_q    <= '0;
      blk_coef_q  <= '0;
      blk_out_q   <= '0;
      coef_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      drain_cnt_q <= '0;
      rapx_q      <= 1'b0;
      timeout_q   <= 1'b0;
      dct_start_q <= 1'b0;
      racc_q      <= 1'b1;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nblk_q      <= nblk_d;
      apx_lo_q    <= apx_lo_d;
      apx_hi_q    <= apx_hi_d;
      apx_en_q    <= apx_en_d;
      in_cnt_q    <= in_cnt_d;
      blk_in_q    <= blk_in_d;
      blk_coef_q  <= blk_coef_d;
      blk_out_q   <= blk_out_d;
      coef_cnt_q  <= coef_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rapx_q      <= rapx_d;
      timeout_q   <= timeout_d;
      dct_start_q <= (state_d == RUN);
      racc_q      <= (state_d == IDLE);
      busy_q      <= (state_d == RUN) || (state_d == DRAIN);
      fin_q       <= (state_d == FIN);
    end
  end

  assign dct_start = dct_start_q;
  assign idct_racc = racc_q;
  assign idct_rapx = rapx_q;
  assign busy      = busy_q;
  assign fin       = fin_q;
  assign timeout   = timeout_q;
  assign blk_out   = blk_out_q;
endmodule
